// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: 32 shift-add or restoring-subtract
// steps followed by a sign-fix cycle, with a pipeline stall while a result is pending.
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mdu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_res, neg_rem, b_zero;
  logic [WIDTH-1:0]   a_raw, opb;
  logic [WIDTH:0]     acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH:0]     hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // start is a request accepted only in IDLE without flush; busy is the
  // "not ready" indication, and the requester holds start (via stall) until busy drops.
  always_comb begin
    sign_a    = mdu_op[0] & A[WIDTH-1];
    sign_b    = mdu_op[0] & B[WIDTH-1];
    abs_a     = sign_a ? (~A + 1'b1) : A;
    abs_b     = sign_b ? (~B + 1'b1) : B;

    mul_sum   = acc_lo[0] ? (acc_hi + {1'b0, opb}) : acc_hi;
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};

    hi_next   = {1'b0, mul_sum[WIDTH:1]};
    lo_next   = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        hi_next = div_diff;
        lo_next = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_shift;
        lo_next = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end

    prod      = {acc_hi[WIDTH-1:0], acc_lo};
    prod_fix  = neg_res ? (~prod + 1'b1) : prod;
    quot_fix  = neg_res ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix   = neg_rem ? (~acc_hi[WIDTH-1:0] + 1'b1) : acc_hi[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      done    <= 1'b0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      a_raw   <= '0;
      opb     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush) begin
            if (start) begin
              state   <= CALC;
              cnt     <= '0;
              is_div  <= mdu_op[1];
              neg_res <= sign_a ^ sign_b;
              neg_rem <= sign_a;
              b_zero  <= (B == '0);
              a_raw   <= A;
              opb     <= abs_b;
              acc_hi  <= '0;
              acc_lo  <= abs_a;
            end else begin
              if (hi_we) hi_r <= wdata;
              if (lo_we) lo_r <= wdata;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc_hi <= hi_next;
            acc_lo <= lo_next;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div && b_zero) begin
              hi_r <= a_raw;
              lo_r <= '1;
            end else if (is_div) begin
              hi_r <= rem_fix;
              lo_r <= quot_fix;
            end else begin
              hi_r <= prod_fix[2*WIDTH-1:WIDTH];
              lo_r <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HI        = hi_r;
  assign LO        = lo_r;
  assign busy      = (state != IDLE);
  assign stall     = busy & (start | rd_hi | rd_lo | hi_we | lo_we);
  assign state_dbg = state;

endmodule
